// File: rtl/updown_counter_mod.sv
// -----------------------------------------------------------------------------
// updown_counter_mod
//
// Parametrised up/down counter with count enable, synchronous parallel load,
// run-time wrap/saturate selection, a terminal-count decode and one-cycle
// wrap / saturation event pulses. With default parameters, sat_mode=0, en=1
// and load=0 it behaves like the original fixed 3-bit up/down counter.
//
// Parameters:
//   WIDTH        counter width in bits (>= 1)
//   MAX          highest count value, 1 <= MAX <= 2**WIDTH-1
//   RESET_VALUE  counter value after reset, 0 <= RESET_VALUE <= MAX
//
// Ports:
//   clk         in   1      clock, all state updates on the rising edge
//   reset       in   1      synchronous active-high reset
//   en          in   1      count enable
//   updown      in   1      1 = count up, 0 = count down
//   sat_mode    in   1      1 = saturate at limits, 0 = wrap modulo MAX+1
//   load        in   1      synchronous parallel load strobe
//   load_value  in   WIDTH  value to load (clamped to MAX)
//   counter     out  WIDTH  current count (registered)
//   tc          out  1      terminal count: at the limit in the current direction
//   wrap        out  1      registered pulse: counter just wrapped
//   sat_hit     out  1      registered pulse: a count was blocked at a limit
// -----------------------------------------------------------------------------
module updown_counter_mod #(
    parameter int WIDTH       = 3,
    parameter int MAX         = 2**WIDTH - 1,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             updown,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             wrap,
    output logic             sat_hit
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ZERO_V = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

    logic [WIDTH-1:0] counter_r;
    logic             wrap_r;
    logic             sat_hit_r;

    logic [WIDTH-1:0] counter_nxt_s;
    logic             wrap_nxt_s;
    logic             sat_hit_nxt_s;
    logic             at_max_s;
    logic             at_zero_s;

    // Limit decodes shared by the next-state logic and the tc output.
    assign at_max_s  = (counter_r == MAX_V);
    assign at_zero_s = (counter_r == ZERO_V);

    // Next-state and event-pulse computation; reset priority is applied in the register.
    always_comb begin
        counter_nxt_s = counter_r;
        wrap_nxt_s    = 1'b0;
        sat_hit_nxt_s = 1'b0;
        if (load) begin
            // Out-of-range load values are clamped so the count never leaves 0..MAX.
            if (load_value > MAX_V) begin
                counter_nxt_s = MAX_V;
            end else begin
                counter_nxt_s = load_value;
            end
        end else if (en) begin
            case (updown)
                1'b1: begin
                    if (at_max_s) begin
                        if (sat_mode) begin
                            sat_hit_nxt_s = 1'b1;
                        end else begin
                            counter_nxt_s = ZERO_V;
                            wrap_nxt_s    = 1'b1;
                        end
                    end else begin
                        counter_nxt_s = counter_r + ONE_V;
                    end
                end
                1'b0: begin
                    if (at_zero_s) begin
                        if (sat_mode) begin
                            sat_hit_nxt_s = 1'b1;
                        end else begin
                            counter_nxt_s = MAX_V;
                            wrap_nxt_s    = 1'b1;
                        end
                    end else begin
                        counter_nxt_s = counter_r - ONE_V;
                    end
                end
                default: begin
                    counter_nxt_s = counter_r;
                end
            endcase
        end else begin
            counter_nxt_s = counter_r;
        end
    end

    // State register with synchronous reset; pulses are aligned with the post-event count.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter_r <= RST_V;
            wrap_r    <= 1'b0;
            sat_hit_r <= 1'b0;
        end else begin
            counter_r <= counter_nxt_s;
            wrap_r    <= wrap_nxt_s;
            sat_hit_r <= sat_hit_nxt_s;
        end
    end

    assign counter = counter_r;
    assign wrap    = wrap_r;
    assign sat_hit = sat_hit_r;
    assign tc      = updown ? at_max_s : at_zero_s;

endmodule

// File: tb/tb_updown_counter_mod.sv
// -----------------------------------------------------------------------------
// Testbench for updown_counter_mod. Two instances share one stimulus stream:
//   dut_a : WIDTH=3, MAX=7, RESET_VALUE=0 (defaults)
//   dut_b : WIDTH=3, MAX=5, RESET_VALUE=2
// The stimulus process applies directed and random inputs, runs an
// arithmetic reference model for each instance and pushes the expected
// outputs into per-instance queues; a monitor pops and compares after
// every rising edge.
// -----------------------------------------------------------------------------
module tb_updown_counter_mod;

    typedef struct {
        int cnt;
        bit wrap;
        bit sat;
        bit tc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic       updown;
    logic       sat_mode;
    logic       load;
    logic [2:0] load_value;

    logic [2:0] cnt_a;
    logic       tc_a;
    logic       wrap_a;
    logic       sat_a;
    logic [2:0] cnt_b;
    logic       tc_b;
    logic       wrap_b;
    logic       sat_b;

    exp_t qa[$];
    exp_t qb[$];
    int   ma;
    int   mb;
    int   checks;
    int   errors;
    bit   done;

    updown_counter_mod #(.WIDTH(3), .MAX(7), .RESET_VALUE(0)) dut_a (
        .clk(clk), .reset(reset), .en(en), .updown(updown), .sat_mode(sat_mode),
        .load(load), .load_value(load_value),
        .counter(cnt_a), .tc(tc_a), .wrap(wrap_a), .sat_hit(sat_a)
    );

    updown_counter_mod #(.WIDTH(3), .MAX(5), .RESET_VALUE(2)) dut_b (
        .clk(clk), .reset(reset), .en(en), .updown(updown), .sat_mode(sat_mode),
        .load(load), .load_value(load_value),
        .counter(cnt_b), .tc(tc_b), .wrap(wrap_b), .sat_hit(sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one edge of the counter, computed with plain integers.
    function automatic exp_t model(input int c, input int mx, input int rv,
                                   input bit r, input bit e, input bit u,
                                   input bit s, input bit l, input int lv);
        exp_t x;
        int   nxt;
        x.cnt  = c;
        x.wrap = 1'b0;
        x.sat  = 1'b0;
        if (r) begin
            x.cnt = rv;
        end else if (l) begin
            x.cnt = (lv > mx) ? mx : lv;
        end else if (e) begin
            nxt = u ? c + 1 : c - 1;
            if (nxt > mx || nxt < 0) begin
                if (s) begin
                    x.sat = 1'b1;
                end else begin
                    x.cnt  = (nxt + mx + 1) % (mx + 1);
                    x.wrap = 1'b1;
                end
            end else begin
                x.cnt = nxt;
            end
        end
        x.tc = u ? (x.cnt == mx) : (x.cnt == 0);
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the expected post-edge outputs.
    task automatic drive(input bit r, input bit e, input bit u, input bit s,
                         input bit l, input int lv);
        exp_t xa;
        exp_t xb;
        @(negedge clk);
        reset      = r;
        en         = e;
        updown     = u;
        sat_mode   = s;
        load       = l;
        load_value = 3'(lv);
        xa = model(ma, 7, 0, r, e, u, s, l, lv);
        xb = model(mb, 5, 2, r, e, u, s, l, lv);
        ma = xa.cnt;
        mb = xb.cnt;
        qa.push_back(xa);
        qb.push_back(xb);
    endtask

    // Monitor: every edge presents a new output set; compare it with the queued expectation.
    always @(posedge clk) begin
        exp_t ea;
        exp_t eb;
        #1;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("a_counter", int'(cnt_a), ea.cnt);
            chk("a_wrap", int'(wrap_a), int'(ea.wrap));
            chk("a_sat_hit", int'(sat_a), int'(ea.sat));
            chk("a_tc", int'(tc_a), int'(ea.tc));
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_counter", int'(cnt_b), eb.cnt);
            chk("b_wrap", int'(wrap_b), int'(eb.wrap));
            chk("b_sat_hit", int'(sat_b), int'(eb.sat));
            chk("b_tc", int'(tc_b), int'(eb.tc));
        end
    end

    initial begin
        reset      = 1'b1;
        en         = 1'b0;
        updown     = 1'b1;
        sat_mode   = 1'b0;
        load       = 1'b0;
        load_value = 3'd0;
        ma         = 0;
        mb         = 0;
        checks     = 0;
        errors     = 0;
        done       = 1'b0;

        // Reset for two cycles; en/load/updown must be ignored.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        // Count up in wrap mode across the boundary.
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        // Count down from reset across the boundary.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        // Saturate: load 3, count up into the top limit, then down into zero.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        // Load out of range with en high: clamped, no increment.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 7);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        // Hold with en low, then toggle direction each cycle.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, i[0], 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, ~i[0], 1'b0, 1'b0, 0);
        // Reset in the same cycle as a pending up-wrap, then resume.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)));
        end

        repeat (3) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
